cpu_oam_dma: RTL

- Sits between the 6502 CPU bus (cpu modport) and the memory/mapper side (mem modport) of the NES CPU subsystem.
- Passes CPU traffic through transparently.
- A CPU write to the sprite-DMA register stalls the CPU via rdy and copies one 256-byte page to the PPU OAM data port with alternating read/write cycles, matching NES cycle counts (513/514).

---
 rtl/cpu_oam_dma_pkg.sv | 15 +
 rtl/cpu_oam_dma_if.sv | 36 +++
 rtl/cpu_oam_dma.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_oam_dma_pkg.sv
// Shared constants for the CPU-side sprite DMA bridge: state codes and default bus addresses.
package cpu_dma_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    typedef logic [2:0] dma_state_t;

    localparam dma_state_t ST_IDLE  = 3'd0;
    localparam dma_state_t ST_HALT  = 3'd1;
    localparam dma_state_t ST_ALIGN = 3'd2;
    localparam dma_state_t ST_RD    = 3'd3;
    localparam dma_state_t ST_WR    = 3'd4;

endpackage

// File: rtl/cpu_oam_dma_if.sv
// CPU-bus / memory-bus bundle seen by the sprite DMA bridge.
interface cpu_oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [7:0]  mem_rdata;

    // The bridge itself.
    modport master (
        input  cpu_addr, cpu_dout, cpu_ren, cpu_wen, mem_rdata,
        output cpu_din, cpu_rdy, mem_addr, mem_wdata, mem_ren, mem_wen
    );

    // Everything around the bridge (CPU plus memory/mapper).
    modport slave (
        output cpu_addr, cpu_dout, cpu_ren, cpu_wen, mem_rdata,
        input  cpu_din, cpu_rdy, mem_addr, mem_wdata, mem_ren, mem_wen
    );

    modport cpu (
        output cpu_addr, cpu_dout, cpu_ren, cpu_wen,
        input  cpu_din, cpu_rdy
    );

    modport mem (
        input  mem_addr, mem_wdata, mem_ren, mem_wen,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_oam_dma.sv
// Transparent CPU-to-memory bridge that performs NES sprite DMA ($4014) into the OAM data port,
// stalling the CPU through cpu_rdy for 513/514 CPU cycles.
module cpu_oam_dma
    import cpu_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = cpu_dma_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = cpu_dma_pkg::OAM_DATA_ADDR,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cyc_en,
    cpu_oam_dma_if.master      bus,
    output logic               dma_active
);

    localparam int unsigned CW = $clog2(XFER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XFER_LEN - 1);

    dma_state_t    r_state, w_state_d;
    logic          r_parity;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [7:0]    r_page, w_page_d;
    logic [7:0]    r_latch, w_latch_d;

    logic          w_trigger;
    logic          w_busy;
    logic [7:0]    w_src_lo;

    assign w_trigger = bus.cpu_wen && (bus.cpu_addr == DMA_REG_ADDR);
    assign w_busy    = (r_state != ST_IDLE);
    // Source offset stays inside the page; the counter never carries into the page byte.
    assign w_src_lo  = 8'(r_cnt);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_page_d  = r_page;
        w_latch_d = r_latch;
        if (cyc_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        w_page_d  = bus.cpu_dout;
                        w_state_d = ST_HALT;
                    end
                end
                // Odd cycle in HALT needs one extra dummy cycle so reads land on even cycles.
                ST_HALT:  w_state_d = r_parity ? ST_ALIGN : ST_RD;
                ST_ALIGN: w_state_d = ST_RD;
                ST_RD: begin
                    w_latch_d = bus.mem_rdata;
                    w_state_d = ST_WR;
                end
                ST_WR: begin
                    if (r_cnt == LAST) begin
                        w_cnt_d   = '0;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_cnt_d   = r_cnt + CW'(1);
                        w_state_d = ST_RD;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_parity <= 1'b0;
            r_cnt    <= '0;
            r_page   <= 8'h00;
            r_latch  <= 8'h00;
        end else begin
            r_state  <= w_state_d;
            r_parity <= r_parity ^ cyc_en;
            r_cnt    <= w_cnt_d;
            r_page   <= w_page_d;
            r_latch  <= w_latch_d;
        end
    end

    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_dout;
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.mem_ren = bus.cpu_ren;
                bus.mem_wen = bus.cpu_wen;
            end
            ST_RD: begin
                bus.mem_addr  = {r_page, w_src_lo};
                bus.mem_wdata = r_latch;
                bus.mem_ren   = 1'b1;
            end
            ST_WR: begin
                bus.mem_addr  = OAM_DATA_ADDR;
                bus.mem_wdata = r_latch;
                bus.mem_wen   = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            bus.mem_ren = 1'b0;
            bus.mem_wen = 1'b0;
        end
    end

    assign bus.cpu_din = bus.mem_rdata;
    assign bus.cpu_rdy = ~w_busy;
    assign dma_active  = w_busy;

endmodule
